// File: rtl/temp_log_pkg.sv
`default_nettype none
// ============================================================================
// temp_log_pkg : shared sizing, record type and LED helper for the ADC logger
// Rev 1.0
// ============================================================================
package temp_log_pkg;

    localparam int DATA_W     = 12;
    localparam int CH_W       = 5;
    localparam int NUM_CH     = 2;
    localparam int AVG_LOG2   = 4;
    localparam int DEPTH_LOG2 = 6;
    localparam int LED_LOG2   = 3;

    localparam int REC_W = CH_W + DATA_W;
    localparam int OVF_W = 16;
    localparam int LED_W = 1 << LED_LOG2;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int CHI_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] avg;
    } rec_t;

    // Thermometer bar from the top LED_LOG2 bits; level 0 still lights bit 0.
    function automatic logic [LED_W-1:0] led_therm(input logic [DATA_W-1:0] avg);
        logic [LED_LOG2-1:0] lvl;
        logic [LED_W-1:0]    bar;
        lvl = avg[DATA_W-1 -: LED_LOG2];
        for (int i = 0; i < LED_W; i++) begin
            bar[i] = (i <= int'(lvl));
        end
        return bar;
    endfunction

endpackage
`default_nettype wire

// File: rtl/temp_log_if.sv
`default_nettype none
// ============================================================================
// temp_log_if : ADC response, host control/readback and display bundle
// Rev 1.0
// ============================================================================
interface temp_log_if;
    import temp_log_pkg::*;

    logic                  in_valid;
    logic [CH_W-1:0]       in_ch;
    logic [DATA_W-1:0]     in_data;
    logic                  wrap_mode;
    logic                  clear;
    logic [CH_W-1:0]       disp_ch;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [REC_W-1:0]      rd_data;
    logic                  avg_valid;
    logic [CH_W-1:0]       avg_ch;
    logic [DATA_W-1:0]     avg_data;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic [OVF_W-1:0]      ovf_cnt;
    logic [DATA_W-1:0]     min_val;
    logic [DATA_W-1:0]     max_val;
    logic [LED_W-1:0]      led;

    modport master (
        output in_valid, in_ch, in_data, wrap_mode, clear, disp_ch, rd_idx,
        input  rd_data, avg_valid, avg_ch, avg_data, count, full, ovf_cnt,
               min_val, max_val, led
    );

    modport slave (
        input  in_valid, in_ch, in_data, wrap_mode, clear, disp_ch, rd_idx,
        output rd_data, avg_valid, avg_ch, avg_data, count, full, ovf_cnt,
               min_val, max_val, led
    );

endinterface
`default_nettype wire

// File: rtl/temp_log_ring.sv
`default_nettype none
// ============================================================================
// temp_log_ring : simple dual-port record RAM, sync write, registered read
// Rev 1.0
// ============================================================================
module temp_log_ring
    import temp_log_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [REC_W-1:0]      i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [REC_W-1:0]      o_rdata
);

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [REC_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read-during-write returns the old word, matching block-RAM behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/temp_log_ctrl.sv
`default_nettype none
// ============================================================================
// temp_log_ctrl : per-channel ADC averager, ring-buffer logger, min/max, LED bar
// Rev 1.0
// ============================================================================
module temp_log_ctrl
    import temp_log_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    temp_log_if.slave bus
);

    localparam logic [CNT_W-1:0]    c_cnt_last = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [DEPTH_LOG2:0] c_depth    = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [OVF_W-1:0]    c_ovf_max  = '1;

    logic [ACC_W-1:0]      r_acc [NUM_CH];
    logic [CNT_W-1:0]      r_cnt [NUM_CH];
    logic                  r_avg_valid;
    logic                  r_drop;
    rec_t                  r_rec;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [OVF_W-1:0]      r_ovf;
    logic [DATA_W-1:0]     r_min;
    logic [DATA_W-1:0]     r_max;
    logic [LED_W-1:0]      r_led;

    logic [CHI_W-1:0]      w_idx;
    logic                  w_accept;
    logic                  w_done;
    logic [ACC_W-1:0]      w_sum;
    logic                  w_keep;
    logic                  w_full;
    logic                  w_we;
    logic [DEPTH_LOG2-1:0] w_raddr;
    logic [REC_W-1:0]      w_rdata;

    assign w_idx    = bus.in_ch[CHI_W-1:0];
    assign w_accept = bus.in_valid && (bus.in_ch < CH_W'(NUM_CH));
    assign w_sum    = r_acc[w_idx] + ACC_W'(bus.in_data);
    assign w_done   = w_accept && (r_cnt[w_idx] == c_cnt_last);

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst || bus.clear) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end else if (w_accept && (w_idx == CHI_W'(i))) begin
                r_acc[i] <= w_done ? '0 : w_sum;
                r_cnt[i] <= w_done ? '0 : r_cnt[i] + 1'b1;
            end
        end
    end

    // A record finishing under clear is still announced but never logged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_avg_valid <= 1'b0;
            r_drop      <= 1'b0;
            r_rec       <= '0;
        end else begin
            r_avg_valid <= w_done;
            r_drop      <= bus.clear;
            if (w_done) begin
                r_rec.ch  <= bus.in_ch;
                r_rec.avg <= DATA_W'(w_sum >> AVG_LOG2);
            end
        end
    end

    assign w_keep = r_avg_valid && !r_drop && !bus.clear;
    assign w_full = (r_count == c_depth);
    assign w_we   = w_keep && !rst && (!w_full || bus.wrap_mode);

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= '0;
        end else if (w_keep) begin
            if (!w_full) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_count  <= r_count + 1'b1;
            end else if (bus.wrap_mode) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end else if (r_ovf != c_ovf_max) begin
                r_ovf <= r_ovf + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_min <= '1;
            r_max <= '0;
        end else if (w_keep && (r_rec.ch == bus.disp_ch)) begin
            if (r_rec.avg < r_min) r_min <= r_rec.avg;
            if (r_rec.avg > r_max) r_max <= r_rec.avg;
        end
    end

    // The bar survives clear; only reset blanks it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= '0;
        end else if (r_avg_valid && (r_rec.ch == bus.disp_ch)) begin
            r_led <= led_therm(r_rec.avg);
        end
    end

    assign w_raddr = r_rd_ptr + bus.rd_idx;

    temp_log_ring u_ring (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (r_rec),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign bus.rd_data   = w_rdata;
    assign bus.avg_valid = r_avg_valid;
    assign bus.avg_ch    = r_rec.ch;
    assign bus.avg_data  = r_rec.avg;
    assign bus.count     = r_count;
    assign bus.full      = w_full;
    assign bus.ovf_cnt   = r_ovf;
    assign bus.min_val   = r_min;
    assign bus.max_val   = r_max;
    assign bus.led       = r_led;

endmodule
`default_nettype wire

// File: tb/tb_temp_log_ctrl.sv
`default_nettype none
// ============================================================================
// tb_temp_log_ctrl : directed stimulus with an average scoreboard for temp_log_ctrl
// Rev 1.0
// ============================================================================
module tb_temp_log_ctrl;
    import temp_log_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    temp_log_if bus();

    temp_log_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [REC_W-1:0] sb [$];
    int m_acc [NUM_CH];
    int m_cnt [NUM_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic send(input int ch, input int data, input logic clr);
        logic [REC_W-1:0] rec;
        bus.in_valid = 1'b1;
        bus.in_ch    = CH_W'(ch);
        bus.in_data  = DATA_W'(data);
        bus.clear    = clr;
        if (ch < NUM_CH) begin
            m_acc[ch] += data;
            m_cnt[ch]++;
            if (m_cnt[ch] == 16) begin
                rec = {CH_W'(ch), DATA_W'(m_acc[ch] / 16)};
                sb.push_back(rec);
                m_acc[ch] = 0;
                m_cnt[ch] = 0;
            end
        end
        if (clr) model_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
    endtask

    task automatic avg_rec(input int ch, input int val);
        for (int i = 0; i < 16; i++) send(ch, val, 1'b0);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        model_reset();
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic read_chk(input string tag, input int idx, input logic [REC_W-1:0] exp);
        bus.rd_idx = DEPTH_LOG2'(idx);
        @(negedge clk);
        check(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    // Every avg_valid pulse must match the oldest outstanding expected record.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.avg_valid === 1'b1) begin
            check("sb_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                check("avg_record", 32'({bus.avg_ch, bus.avg_data}), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_ch     = '0;
        bus.in_data   = '0;
        bus.wrap_mode = 1'b1;
        bus.clear     = 1'b0;
        bus.disp_ch   = '0;
        bus.rd_idx    = '0;
        model_reset();
        repeat (3) @(negedge clk);

        check("rst_avg_valid", 32'(bus.avg_valid), 32'd0);
        check("rst_avg_data",  32'(bus.avg_data),  32'd0);
        check("rst_count",     32'(bus.count),     32'd0);
        check("rst_full",      32'(bus.full),      32'd0);
        check("rst_ovf",       32'(bus.ovf_cnt),   32'd0);
        check("rst_min",       32'(bus.min_val),   32'hFFF);
        check("rst_max",       32'(bus.max_val),   32'd0);
        check("rst_led",       32'(bus.led),       32'd0);
        check("rst_rd_data",   32'(bus.rd_data),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single average on ch0, exact latencies
        for (int i = 0; i < 15; i++) send(0, 'h800, 1'b0);
        check("t1_no_early_valid", 32'(bus.avg_valid), 32'd0);
        send(0, 'h800, 1'b0);
        check("t1_avg_valid", 32'(bus.avg_valid), 32'd1);
        check("t1_avg_data",  32'(bus.avg_data),  32'h800);
        @(negedge clk);
        check("t1_valid_pulse", 32'(bus.avg_valid), 32'd0);
        check("t1_count", 32'(bus.count),   32'd1);
        check("t1_led",   32'(bus.led),     32'h1F);
        check("t1_min",   32'(bus.min_val), 32'h800);
        check("t1_max",   32'(bus.max_val), 32'h800);
        @(negedge clk);
        check("t1_rd_data", 32'(bus.rd_data), 32'h00800);

        // 2: interleaved channels, display ch1
        pulse_clear();
        bus.disp_ch = CH_W'(1);
        for (int i = 0; i < 16; i++) begin
            send(0, 'h100, 1'b0);
            send(1, 'hF00, 1'b0);
        end
        settle();
        check("t2_count", 32'(bus.count),   32'd2);
        check("t2_led",   32'(bus.led),     32'hFF);
        check("t2_min",   32'(bus.min_val), 32'hF00);
        check("t2_max",   32'(bus.max_val), 32'hF00);
        read_chk("t2_rd0", 0, {CH_W'(0), DATA_W'('h100)});
        read_chk("t2_rd1", 1, {CH_W'(1), DATA_W'('hF00)});

        // 3: wrap mode, 70 averages
        pulse_clear();
        bus.disp_ch   = CH_W'(0);
        bus.wrap_mode = 1'b1;
        for (int v = 0; v < 70; v++) avg_rec(0, v);
        settle();
        check("t3_count", 32'(bus.count),   32'd64);
        check("t3_full",  32'(bus.full),    32'd1);
        check("t3_ovf",   32'(bus.ovf_cnt), 32'd0);
        check("t3_min",   32'(bus.min_val), 32'd0);
        check("t3_max",   32'(bus.max_val), 32'd69);
        check("t3_led",   32'(bus.led),     32'h01);
        read_chk("t3_rd0",  0,  {CH_W'(0), DATA_W'(6)});
        read_chk("t3_rd63", 63, {CH_W'(0), DATA_W'(69)});

        // 4: stop mode, 70 averages
        pulse_clear();
        bus.wrap_mode = 1'b0;
        for (int v = 0; v < 70; v++) avg_rec(0, v);
        settle();
        check("t4_count", 32'(bus.count),   32'd64);
        check("t4_full",  32'(bus.full),    32'd1);
        check("t4_ovf",   32'(bus.ovf_cnt), 32'd6);
        check("t4_max",   32'(bus.max_val), 32'd69);
        read_chk("t4_rd0",  0,  {CH_W'(0), DATA_W'(0)});
        read_chk("t4_rd63", 63, {CH_W'(0), DATA_W'(63)});

        // 5: clear coinciding with a completion
        pulse_clear();
        bus.wrap_mode = 1'b1;
        bus.rd_idx    = '0;
        for (int i = 0; i < 15; i++) send(0, 'h300, 1'b0);
        send(0, 'h300, 1'b1);
        check("t5_avg_valid", 32'(bus.avg_valid), 32'd1);
        settle();
        check("t5_count", 32'(bus.count),   32'd0);
        check("t5_min",   32'(bus.min_val), 32'hFFF);
        check("t5_ovf",   32'(bus.ovf_cnt), 32'd0);
        avg_rec(0, 'h123);
        settle();
        check("t5_count_after", 32'(bus.count),   32'd1);
        check("t5_min_after",   32'(bus.min_val), 32'h123);
        read_chk("t5_rd0", 0, {CH_W'(0), DATA_W'('h123)});

        // 6: out-of-range channel dropped, rst discards partial sum
        pulse_clear();
        for (int i = 0; i < 16; i++) send(5, 'h7FF, 1'b0);
        settle();
        check("t6_ch5_count", 32'(bus.count), 32'd0);
        for (int i = 0; i < 8; i++) send(0, 'h400, 1'b0);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) send(0, 'h200, 1'b0);
        check("t6_no_early_valid", 32'(bus.avg_valid), 32'd0);
        check("t6_count_mid",      32'(bus.count),     32'd0);
        send(0, 'h200, 1'b0);
        check("t6_avg_valid", 32'(bus.avg_valid), 32'd1);
        settle();
        check("t6_count", 32'(bus.count), 32'd1);
        check("t6_led",   32'(bus.led),   32'h03);
        read_chk("t6_rd0", 0, {CH_W'(0), DATA_W'('h200)});

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
